// File: rtl/struct_rec_pkg.sv
// Shared types for the byte-to-record packer: element type, default record geometry, record layout, FSM states.
package struct_rec_pkg;

    typedef bit [7:0] byte_t;

    localparam int DEF_NUM_A = 8;
    localparam int REC_BYTES = DEF_NUM_A + 2;
    localparam int REC_W     = DEF_NUM_A * 8 + 16;

    // Element a[0] sits just above b, so a[NUM_A-1] lands in the record MSBs.
    typedef struct packed {
        byte_t [DEF_NUM_A-1:0] a;
        bit    [15:0]          b;
    } record_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/struct_record_packer.sv
// Packs one byte/cycle into {a[], b}; record is valid the cycle after its closing byte is taken.
// While a record is held in_ready stays low, and input reopens only on the cycle after the handoff.
module struct_record_packer
    import struct_rec_pkg::*;
#(
    parameter  int NUM_A   = DEF_NUM_A,
    localparam int N_BYTES = NUM_A + 2,
    localparam int LEN_W   = $clog2(N_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_A*8+16-1:0]  out_data,
    output logic [LEN_W-1:0]       out_len
);

    localparam int K_W = $clog2(N_BYTES);
    localparam int A_W = $clog2(NUM_A);

    // Same layout as record_t, but sized by this instance's NUM_A.
    typedef struct packed {
        byte_t [NUM_A-1:0] a;
        bit    [15:0]      b;
    } rec_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    rec_t             rec_q, rec_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rec_d   = rec_q;
        len_d   = len_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (k_q < K_W'(NUM_A)) begin
                        rec_d.a[k_q[A_W-1:0]] = in_data;
                    end else if (k_q == K_W'(NUM_A)) begin
                        rec_d.b[7:0] = in_data;
                    end else begin
                        rec_d.b[15:8] = in_data;
                    end
                    if (in_last || (k_q == K_W'(N_BYTES - 1))) begin
                        state_d = HOLD;
                        len_d   = LEN_W'(k_q) + LEN_W'(1);
                        k_d     = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            HOLD: begin
                // Clearing on handoff is what makes unwritten bytes of the next short record read as zero.
                if (out_ready) begin
                    state_d = FILL;
                    rec_d   = '0;
                    len_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            k_q     <= '0;
            rec_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rec_q   <= rec_d;
            len_q   <= len_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_data  = rec_q;
    assign out_len   = len_q;

endmodule

// File: tb/tb_struct_record_packer.sv
// Directed and randomized bench for struct_record_packer; expected records come from a byte-list model.
module tb_struct_record_packer;
    import struct_rec_pkg::*;

    localparam int NUM_A = DEF_NUM_A;
    localparam int LEN_W = $clog2(REC_BYTES + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] out_data;
    logic [LEN_W-1:0] out_len;

    logic rand_mode;
    logic dir_rdy;
    logic rnd_rdy;
    assign out_ready = rand_mode ? rnd_rdy : dir_rdy;

    struct_record_packer #(.NUM_A(NUM_A)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_len   (out_len)
    );

    typedef struct {
        logic [REC_W-1:0] d;
        int               len;
    } rec_s;

    rec_s  got[$];
    rec_s  exp_q[$];
    rec_s  seen[$];
    byte_t cur[$];

    int n_cmp = 0;
    int n_bad = 0;
    int hi_cnt;
    int rlen;
    bit use_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    // A handshake seen at the falling edge completes on the next rising edge unless reset is asserted.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back('{out_data, int'(out_len)});
    end

    function automatic logic [REC_W-1:0] build(input byte_t bs[$]);
        logic [REC_W-1:0] v = '0;
        for (int j = 0; j < bs.size(); j++) begin
            if (j < NUM_A)       v |= REC_W'(bs[j]) << (16 + 8 * j);
            else if (j == NUM_A) v |= REC_W'(bs[j]);
            else                 v |= REC_W'(bs[j]) << 8;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte_t d, input bit last);
        int  n    = 0;
        bit  done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            tick();
            n++;
            if (!done && n > 200) begin
                n_cmp++;
                n_bad++;
                $error("FAIL send_timeout: observed in_ready low for %0d cycles, expected acceptance", n);
                done = 1'b1;
            end else if (done) begin
                cur.push_back(d);
                if (last || cur.size() == REC_BYTES) begin
                    exp_q.push_back('{build(cur), cur.size()});
                    cur.delete();
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        tick();
        in_last  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur.delete();
    endtask

    task automatic drain(input string tag);
        int   n = 0;
        rec_s g;
        rec_s e;
        if (!rand_mode) dir_rdy = 1'b1;
        while (got.size() < exp_q.size() && n < 1000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        seen.delete();
        chk({tag, "_count"}, got.size(), exp_q.size());
        while (exp_q.size() > 0 && got.size() > 0) begin
            g = got.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, g.d, e.d);
            chk({tag, "_len"}, g.len, e.len);
            seen.push_back(g);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        rand_mode = 1'b0;
        dir_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_data", out_data, 0);
        tick();

        // Full record with in_last on the final byte; valid must last exactly one cycle.
        dir_rdy = 1'b1;
        for (int i = 0; i < REC_BYTES; i++) send_byte(byte_t'(i), i == REC_BYTES - 1);
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
            tick();
        end
        chk("full_valid_cycles", hi_cnt, 1);
        drain("full");
        chk("full_literal", seen[0].d, 80'h0706_0504_0302_0100_0908);
        chk("full_literal_len", seen[0].len, 10);

        send_byte(8'h42, 1'b0);
        send_byte(8'h12, 1'b1);
        drain("short");
        chk("short_literal", seen[0].d, 80'h0000_0000_0000_1242_0000);
        chk("short_literal_len", seen[0].len, 2);

        // Backpressure: record held for five cycles, then released.
        dir_rdy = 1'b0;
        for (int i = 0; i < REC_BYTES; i++) send_byte(byte_t'($urandom), i == REC_BYTES - 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_data_stable", out_data, exp_q[exp_q.size() - 1].d);
            chk("bp_len_stable", out_len, 10);
            tick();
        end
        dir_rdy = 1'b1;
        @(negedge clk);
        chk("bp_handoff_valid", out_valid, 1'b1);
        chk("bp_handoff_in_ready", in_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("bp_after_in_ready", in_ready, 1'b1);
        chk("bp_after_out_valid", out_valid, 1'b0);
        tick();
        drain("bp");

        for (int i = 0; i < 2 * REC_BYTES; i++) send_byte(byte_t'(i), 1'b0);
        drain("nolast");
        chk("nolast_rec0", seen[0].d, 80'h0706_0504_0302_0100_0908);
        chk("nolast_rec1", seen[1].d, 80'h1110_0F0E_0D0C_0B0A_1312);
        chk("nolast_len1", seen[1].len, 10);

        for (int i = 0; i < 4; i++) send_byte(byte_t'(8'hA0 + i), 1'b0);
        pulse_rst();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        tick();
        send_byte(8'hFF, 1'b1);
        drain("midrst");
        chk("midrst_literal", seen[0].d, 80'h0000_0000_0000_00FF_0000);
        chk("midrst_literal_len", seen[0].len, 1);

        // Reset coinciding with an output handshake: the held record is dropped.
        dir_rdy = 1'b0;
        send_byte(8'h5A, 1'b1);
        tick();
        dir_rdy = 1'b1;
        pulse_rst();
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("hold_rst_out_valid", out_valid, 1'b0);
        chk("hold_rst_out_data", out_data, 0);
        tick();
        drain("hold_rst");

        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        drain("back2back");
        chk("b2b_rec1", seen[1].d, 80'h0000_0000_0000_00CD_0000);
        chk("b2b_len1", seen[1].len, 1);

        rand_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rlen     = $urandom_range(1, REC_BYTES);
            use_last = (rlen < REC_BYTES) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < rlen; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                send_byte(byte_t'($urandom), use_last && (i == rlen - 1));
            end
        end
        drain("random");
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/struct_record_packer.md
# struct_record_packer

Byte-stream to packed-struct assembler that sits directly upstream of the struct-array record consumers. It accepts one byte per cycle on a valid/ready handshake and places each byte into the correct element of a packed record: an 8-bit-element packed array `a`, followed by a 16-bit field `b`. It then presents the completed record on a registered valid/ready output. Records close either on a full byte count or early on `in_last`; unfilled bytes are zero.

## Interface
Parameters:
- `NUM_A`, default 8: number of byte elements in `a`. Record width is `NUM_A*8+16`. `REC_BYTES = NUM_A+2`.

Ports:
- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `in_valid`, input, 1: byte available.
- `in_ready`, output, 1: packer accepts the byte this cycle.
- `in_data`, input, 8: byte value.
- `in_last`, input, 1: the byte is the final byte of the record. Only meaningful with `in_valid`.
- `out_valid`, output, 1: the record is complete and held.
- `out_ready`, input, 1: consumer takes the record.
- `out_data`, output, `NUM_A*8+16`: `record_t`, defined as `{a[NUM_A-1:0], b[15:0]}`, with `a` in the MSBs.
- `out_len`, output, `$clog2(REC_BYTES+1)`: number of bytes received for this record, from 1 to `REC_BYTES`.

## Operation
- A byte is accepted when `in_valid && in_ready`.
- Two states:
  - FILL: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- Byte index `k` counts from 0 within the record. Placement:
  - `k<NUM_A`: byte goes to `a[k]`.
  - `k==NUM_A`: byte goes to `b[7:0]`.
  - `k==NUM_A+1`: byte goes to `b[15:8]`.
- FILL→HOLD occurs on an accepted byte when either `k==REC_BYTES-1` or `in_last=1`.
  - On this transition, `out_len` is set to `k+1`.
  - Index `k` resets to 0.
- HOLD→FILL occurs on `out_valid && out_ready`.
  - On this transition, the record register clears to all-zero and `out_len` clears to 0.
- In HOLD, `out_data` and `out_len` remain stable while `out_ready=0`.
- Any bytes not written in a short record read as 0. The record register is never X after reset.
- If `in_last` arrives on byte `REC_BYTES-1`, it is the same as a full close. No extra flag is produced.
- Bytes presented after a full close without `in_last` start the next record once the packer returns to FILL. There is no overrun error.
- `in_last` without `in_valid` is ignored.

## Timing
- Reset values: FILL state, `k=0`, record register `'0`, `out_len=0`, `out_valid=0`, `in_ready=1`.
- Reset mid-record discards the partial record. Reset during HOLD drops the held record. `out_valid` is 0 on the cycle after `rst` is sampled high.
- Latency: `out_valid` rises on the cycle after the closing byte is accepted.
- Throughput is `REC_BYTES` cycles plus one handoff cycle per record:
  - `in_ready` is 0 for the whole time the packer is in HOLD.
  - `in_ready` is 1 on the cycle after the handoff.
  - There is no same-cycle drain-and-accept.
- `out_valid`, `out_data` and `out_len` are registered. `in_ready` is a decode of the state register only and has no combinational path from `out_ready`.
- Simultaneous `rst` and a handshake: reset wins, and the handshake has no effect.

## Structure
- Package `struct_rec_pkg` holds:
  - `byte_t` (`bit [7:0]`).
  - `NUM_A`-default constants `REC_BYTES` and `REC_W`.
  - `record_t`, a packed struct `{byte_t [NUM_A-1:0] a; bit [15:0] b;}`.
  - State enum `{FILL, HOLD}`.
- Writes use struct member and packed-array element indexing (`rec.a[k]`, `rec.b[7:0]`) rather than flat bit offsets. Those indexing paths are what this block exercises.
- Single module; no sub-module is warranted.

## Test plan
- Full record: bytes 00..09 with `in_last` on 09, `out_ready=1`. Required: `out_data=80'h0706_0504_0302_0100_0908`, `out_len=10`, `out_valid` high for exactly 1 cycle.
- Short record: bytes 42 then 12 (with `in_last`). Required: `out_data=80'h0000_0000_0000_1242_0000`, `out_len=2`.
- Backpressure: complete a full record with `out_ready=0` for 5 cycles. Required: `out_data` and `out_len` stable, `in_ready=0` throughout, handoff on the first `out_ready=1` cycle, `in_ready=1` on the next cycle.
- No `in_last`: stream 20 bytes 00..13 continuously with `out_ready=1`. Required: two records, `80'h0706_0504_0302_0100_0908` and `80'h1110_0F0E_0D0C_0B0A_1312`, each with `out_len=10`.
- Reset mid-record: after 4 bytes, pulse `rst`, then send FF with `in_last`. Required: `out_data=80'h0000_0000_0000_00FF_0000`, `out_len=1`.
- Byte after short record: send AB (with `in_last`), then immediately CD (with `in_last`). Required: two records with `out_len=1`, and the second record has `a[0]=CD` with all other bytes 0.
